// File: rtl/paillier_arb_pkg.sv
// paillier_arb_pkg: shared arbiter FSM states and default bank geometry
package paillier_arb_pkg;
    localparam int K_DEF = 128;
    localparam int N_DEF = 32;
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;
endpackage

// File: rtl/shift_engine_arbiter_if.sv
// shift_engine_arbiter_if: requester handshake, engine port and bank port bundle
interface shift_engine_arbiter_if #(
    parameter int K = 128,
    parameter int N = 32,
    parameter int R = 4,
    parameter int ADDR_W = $clog2(N),
    parameter int RID_W = $clog2(R)
);
    logic [R-1:0]     req;
    logic [R-1:0]     done;
    logic             busy;
    logic [RID_W-1:0] grant_id;
    logic             eng_start;
    logic             eng_end;
    logic [ADDR_W-1:0] eng_rd_addr;
    logic [K-1:0]     eng_rd_data;
    logic [ADDR_W-1:0] eng_wr_addr;
    logic [K-1:0]     eng_wr_data;
    logic             eng_wr_en;
    logic [ADDR_W-1:0] bank_rd_addr;
    logic [R*K-1:0]   bank_rd_data;
    logic [ADDR_W-1:0] bank_wr_addr;
    logic [K-1:0]     bank_wr_data;
    logic [R-1:0]     bank_wr_en;
    modport master (
        input  req, eng_end, eng_rd_addr, eng_wr_addr, eng_wr_data, eng_wr_en, bank_rd_data,
        output done, busy, grant_id, eng_start, eng_rd_data, bank_rd_addr, bank_wr_addr,
               bank_wr_data, bank_wr_en
    );
    modport slave (
        output req, eng_end, eng_rd_addr, eng_wr_addr, eng_wr_data, eng_wr_en, bank_rd_data,
        input  done, busy, grant_id, eng_start, eng_rd_data, bank_rd_addr, bank_wr_addr,
               bank_wr_data, bank_wr_en
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner select; rotate by ptr, take lowest set bit, rotate back
module rr_pick #(
    parameter int R = 4,
    parameter int RID_W = $clog2(R)
) (
    input  logic [R-1:0]     req_i,
    input  logic [RID_W-1:0] ptr_i,
    output logic [RID_W-1:0] winner_o,
    output logic             valid_o
);
    logic [R-1:0]     rot;
    logic [RID_W-1:0] off;
    logic [RID_W:0]   sum;
    always_comb begin
        rot = R'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = R - 1; i >= 0; i--)
            if (rot[i]) off = RID_W'(i);
        sum = {1'b0, ptr_i} + {1'b0, off};
        winner_o = sum >= (RID_W+1)'(R) ? RID_W'(sum - (RID_W+1)'(R)) : RID_W'(sum);
        valid_o = |req_i;
    end
endmodule

// File: rtl/shift_engine_arbiter.sv
// shift_engine_arbiter: time-shares one right-shift engine among R operand banks,
// routing the engine memory ports to the granted bank with no added latency.
module shift_engine_arbiter
    import paillier_arb_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int R = 4,
    parameter int RID_W = $clog2(R)
) (
    input logic clk,
    input logic rst_n,
    shift_engine_arbiter_if.master bus
);
    state_e           state_q, state_d;
    logic [RID_W-1:0] ptr_q, ptr_d, grant_q, grant_d;
    logic [RID_W-1:0] winner;
    logic             valid;
    logic             wr_window;

    rr_pick #(.R(R), .RID_W(RID_W)) u_pick (
        .req_i(bus.req),
        .ptr_i(ptr_q),
        .winner_o(winner),
        .valid_o(valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // eng_end only matters in RUN; a stray or unknown value elsewhere is dropped
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (valid) begin
                grant_d = winner;
                state_d = START;
            end
            START: state_d = RUN;
            RUN: if (bus.eng_end === 1'b1) state_d = DONE;
            DONE: begin
                ptr_d   = grant_q == RID_W'(R - 1) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_window        = state_q == START || state_q == RUN;
    assign bus.busy         = state_q != IDLE;
    assign bus.eng_start    = state_q == START;
    assign bus.grant_id     = grant_q;
    assign bus.done         = state_q == DONE ? R'(1) << grant_q : '0;
    assign bus.bank_wr_en   = wr_window && bus.eng_wr_en ? R'(1) << grant_q : '0;
    assign bus.bank_rd_addr = bus.eng_rd_addr;
    assign bus.bank_wr_addr = bus.eng_wr_addr;
    assign bus.bank_wr_data = bus.eng_wr_data;
    assign bus.eng_rd_data  = bus.bank_rd_data[grant_q*K +: K];
endmodule

// File: tb/tb_shift_engine_arbiter.sv
// tb_shift_engine_arbiter: bank/engine models around the arbiter, scoreboard of expected grants
module tb_shift_engine_arbiter;
    localparam int K = 128;
    localparam int N = 32;
    localparam int R = 4;
    localparam int ADDR_W = $clog2(N);
    localparam int RID_W = $clog2(R);

    logic clk = 0;
    logic rst_n;
    logic [R-1:0] req, hold;
    logic spur, eng_end_e, pl, eng_wr_en;
    logic [ADDR_W-1:0] eng_rd_addr, eng_wr_addr;
    logic [K-1:0] eng_wr_data;
    logic [K-1:0] bank [R][N];
    int total = 0, bad = 0, starts = 0, stray = 0, dones = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    shift_engine_arbiter_if #(.K(K), .N(N), .R(R)) ifc ();
    shift_engine_arbiter #(.K(K), .R(R)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));

    assign ifc.req         = req;
    assign ifc.eng_end     = eng_end_e | spur;
    assign ifc.eng_rd_addr = eng_rd_addr;
    assign ifc.eng_wr_addr = eng_wr_addr;
    assign ifc.eng_wr_data = eng_wr_data;
    assign ifc.eng_wr_en   = eng_wr_en;
    for (genvar g = 0; g < R; g++) begin : g_rd
        assign ifc.bank_rd_data[g*K +: K] = bank[g][ifc.bank_rd_addr];
    end

    function automatic logic [K-1:0] init_word(int b, int w);
        return b == 0 ? K'(w) : {32'(b), 32'(w), 32'hC0DE_0000 | 32'(w), 32'(b * 97 + w)};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < R; i++)
            for (int j = 0; j < N; j++)
                if (pl) bank[i][j] <= init_word(i, j);
                else if (ifc.bank_wr_en[i] && ifc.bank_wr_addr == ADDR_W'(j)) bank[i][j] <= ifc.bank_wr_data;
    end

    // engine: one word per cycle from N-1 down to 0, eng_end N+3 cycles after eng_start
    task automatic run_engine();
        logic carry;
        carry = 1'b0;
        for (int a = N - 1; a >= 0; a--) begin
            @(posedge clk); #1;
            if (!rst_n) begin eng_wr_en = 0; return; end
            eng_rd_addr = ADDR_W'(a);
            #1;
            eng_wr_addr = ADDR_W'(a);
            eng_wr_data = {carry, ifc.eng_rd_data[K-1:1]};
            carry = ifc.eng_rd_data[0];
            eng_wr_en = 1;
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            eng_wr_en = 0;
            if (!rst_n) return;
        end
        eng_end_e = 1;
        @(posedge clk); #1;
        eng_end_e = 0;
    endtask

    initial begin
        eng_rd_addr = '0; eng_wr_addr = '0; eng_wr_data = '0; eng_wr_en = 0; eng_end_e = 0;
        forever begin
            @(negedge clk);
            if (rst_n && ifc.eng_start) run_engine();
        end
    end

    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ifc.eng_start) starts++;
                if (|ifc.bank_wr_en[R-1:1]) stray++;
                if (ifc.done != '0) begin
                    dones++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected act done=%b grant=%0d", ifc.done, ifc.grant_id);
                    end else begin
                        e = exp_q.pop_front();
                        if (ifc.done !== R'(1) << e || ifc.grant_id !== RID_W'(e)) begin
                            bad++;
                            $display("FAIL done_order act done=%b grant=%0d exp grant=%0d", ifc.done, ifc.grant_id, e);
                        end
                    end
                    for (int i = 0; i < R; i++)
                        if (ifc.done[i] && !hold[i]) req[i] = 0;
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(string name);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ifc.busy) return;
        end
        total++; bad++;
        $display("FAIL %s timeout act pending=%0d exp pending=0", name, exp_q.size());
        exp_q.delete();
    endtask

    task automatic wait_start(int id);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (ifc.eng_start && ifc.grant_id == RID_W'(id)) return;
        end
        total++; bad++;
        $display("FAIL start_%0d timeout act=none exp=eng_start", id);
    endtask

    task automatic wait_done(int id);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (ifc.done[id]) return;
        end
        total++; bad++;
        $display("FAIL done_%0d timeout act=none exp=done", id);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [N*K-1:0] big;
        int errs, d0;
        rst_n = 0; req = '0; hold = '0; spur = 0; pl = 0;
        repeat (2) @(posedge clk); #1;
        pl = 1;
        @(posedge clk); #1;
        pl = 0;
        @(negedge clk);
        chk("rst_done", int'(ifc.done), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_grant", int'(ifc.grant_id), 0);
        chk("rst_start", int'(ifc.eng_start), 0);
        chk("rst_wr_en", int'(ifc.bank_wr_en), 0);
        rst_n = 1;

        @(posedge clk); #1; spur = 1;
        @(posedge clk); #1; spur = 0;
        @(negedge clk);
        chk("spur_done", int'(ifc.done), 0);
        chk("spur_busy", int'(ifc.busy), 0);
        chk("spur_start", int'(ifc.eng_start), 0);

        starts = 0; stray = 0;
        req = 4'b0001; exp_q.push_back(0);
        wait_idle("single");
        chk("single_starts", starts, 1);
        chk("single_stray_wr", stray, 0);
        for (int j = 0; j < N; j++) big[j*K +: K] = init_word(0, j);
        big = big >> 1;
        errs = 0;
        for (int j = 0; j < N; j++) if (bank[0][j] !== big[j*K +: K]) errs++;
        chk("bank0_shift_words_bad", errs, 0);
        errs = 0;
        for (int i = 1; i < R; i++)
            for (int j = 0; j < N; j++) if (bank[i][j] !== init_word(i, j)) errs++;
        chk("other_banks_words_bad", errs, 0);

        do_reset();
        starts = 0; d0 = dones;
        req = 4'b1111;
        for (int i = 0; i < R; i++) exp_q.push_back(i);
        wait_idle("all");
        chk("all_starts", starts, 4);
        chk("all_dones", dones - d0, 4);

        hold[0] = 1; req[0] = 1; exp_q.push_back(0);
        wait_start(0);
        req[2] = 1; exp_q.push_back(2); exp_q.push_back(0);
        wait_start(2);
        wait_start(0);
        req[2] = 1; exp_q.push_back(2); exp_q.push_back(0);
        wait_start(2);
        wait_start(0);
        hold[0] = 0;
        wait_idle("fair");

        req[1] = 1; exp_q.push_back(1);
        wait_done(1);
        @(posedge clk); #1;
        req[1] = 1; exp_q.push_back(1);
        @(negedge clk);
        chk("b2b_start_d1", int'(ifc.eng_start), 0);
        @(negedge clk);
        chk("b2b_start_d2", int'(ifc.eng_start), 1);
        chk("b2b_grant", int'(ifc.grant_id), 1);
        wait_idle("b2b");

        req[3] = 1;
        wait_start(3);
        repeat (10) @(negedge clk);
        rst_n = 0; req = '0;
        #1;
        chk("mid_rst_busy", int'(ifc.busy), 0);
        chk("mid_rst_wr_en", int'(ifc.bank_wr_en), 0);
        chk("mid_rst_grant", int'(ifc.grant_id), 0);
        chk("mid_rst_start", int'(ifc.eng_start), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        req = 4'b0110; exp_q.push_back(1); exp_q.push_back(2);
        wait_idle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
